// File: rtl/ahb_arb_pkg.sv
// Shared AHB arbiter types: transfer/burst encodings, arbiter states and burst length decode.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY   = 2'd1,
    NONSEQ = 2'd2,
    SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    ARB_OWN   = 2'd0,
    ARB_BURST = 2'd1,
    ARB_LOCK  = 2'd2
  } arb_state_e;

  localparam int BEAT_CNT_W = 4;

  // Undefined-length INCR and SINGLE count as one beat: they never freeze the grant.
  function automatic logic [4:0] burst_beats(hburst_e b);
    case (b)
      WRAP4, INCR4:   burst_beats = 5'd4;
      WRAP8, INCR8:   burst_beats = 5'd8;
      WRAP16, INCR16: burst_beats = 5'd16;
      default:        burst_beats = 5'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_bus_arbiter_if.sv
// Arbiter-facing AHB bus signals; "master" is the fabric side, "slave" is the arbiter side.
interface ahb_bus_arbiter_if #(
  parameter int NUM_MASTERS = 4,
  parameter int MID_W       = $clog2(NUM_MASTERS)
);
  logic [NUM_MASTERS-1:0] HBUSREQ;
  logic [NUM_MASTERS-1:0] HLOCK;
  logic [1:0]             HTRANS;
  logic [2:0]             HBURST;
  logic                   HREADY;
  logic [NUM_MASTERS-1:0] HGRANT;
  logic [MID_W-1:0]       HMASTER;
  logic [MID_W-1:0]       HMASTER_D;
  logic                   HMASTLOCK;

  modport master (
    output HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    input  HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );

  modport slave (
    input  HBUSREQ, HLOCK, HTRANS, HBURST, HREADY,
    output HGRANT, HMASTER, HMASTER_D, HMASTLOCK
  );
endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational next-owner selector: round-robin after last_owner, or fixed priority
// (lowest index first) when AHB_ARB_FIXED_PRIO_EN is defined. Falls back to DEFAULT_MASTER.
module ahb_rr_picker #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MID_W          = $clog2(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
`ifndef AHB_ARB_FIXED_PRIO_EN
  input  logic [MID_W-1:0]       last_owner,
`endif
  output logic [NUM_MASTERS-1:0] grant
);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

`ifdef AHB_ARB_FIXED_PRIO_EN
  always_comb begin
    grant = DEFAULT_GRANT;
    for (int i = NUM_MASTERS - 1; i >= 0; i--)
      if (req[i]) grant = NUM_MASTERS'(1) << i;
  end
`else
  logic [NUM_MASTERS-1:0] req_rot;
  logic [MID_W-1:0]       cand_idx [NUM_MASTERS];

  // Slot gi holds master (last_owner + 1 + gi) mod N; the owner itself sits in the last slot.
  generate
    for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_rot
      logic [MID_W:0] sum;
      assign sum = {1'b0, last_owner} + (MID_W+1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (MID_W+1)'(NUM_MASTERS)) ?
                            MID_W'(sum - (MID_W+1)'(NUM_MASTERS)) : MID_W'(sum);
      assign req_rot[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant = DEFAULT_GRANT;
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (req_rot[k]) grant = NUM_MASTERS'(1) << cand_idx[k];
  end
`endif
endmodule

// File: rtl/ahb_bus_arbiter.sv
// Multi-master AHB arbiter with lock and fixed-burst ownership holding.
// Define AHB_ARB_FIXED_PRIO_EN to replace round-robin with fixed lowest-index priority.
module ahb_bus_arbiter
  import ahb_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  parameter int MID_W          = $clog2(NUM_MASTERS)
) (
  input logic              HCLK,
  input logic              HRESET,
  ahb_bus_arbiter_if.slave bus
);
  localparam logic [NUM_MASTERS-1:0] DEFAULT_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;
  localparam logic [MID_W-1:0]       DEFAULT_MID   = MID_W'(DEFAULT_MASTER);

  function automatic logic [MID_W-1:0] onehot_idx(logic [NUM_MASTERS-1:0] oh);
    onehot_idx = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (oh[i]) onehot_idx = MID_W'(i);
  endfunction

  logic [NUM_MASTERS-1:0] grant_reg;
  logic [MID_W-1:0]       hmaster_reg;
  logic [MID_W-1:0]       hmaster_d_reg;
  logic                   hmastlock_reg;
  logic [BEAT_CNT_W-1:0]  beat_cnt_reg;
  arb_state_e             state_reg;
`ifndef AHB_ARB_FIXED_PRIO_EN
  logic [MID_W-1:0]       rr_ptr_reg;
`endif

  htrans_e                trans;
  hburst_e                burst;
  logic [MID_W-1:0]       owner;
  logic                   fixed_burst;
  logic                   lock_req;
  logic                   final_seq;
  logic                   legal_point;
  logic [NUM_MASTERS-1:0] pick_grant;

  assign trans       = htrans_e'(bus.HTRANS);
  assign burst       = hburst_e'(bus.HBURST);
  assign owner       = onehot_idx(grant_reg);
  assign fixed_burst = burst_beats(burst) != 5'd1;
  assign lock_req    = bus.HLOCK[owner] & bus.HBUSREQ[owner];
  // A counter of 1 on an accepted SEQ means this is the last beat of the fixed burst.
  assign final_seq   = (state_reg == ARB_BURST) && (trans == SEQ) && (beat_cnt_reg == BEAT_CNT_W'(1));
  assign legal_point = !lock_req &&
                       (final_seq ||
                        ((state_reg == ARB_OWN) &&
                         ((trans == IDLE) ||
                          ((trans == NONSEQ) && (burst == SINGLE)) ||
                          ((burst == INCR) && !bus.HBUSREQ[owner]))));

  ahb_rr_picker #(
    .NUM_MASTERS   (NUM_MASTERS),
    .DEFAULT_MASTER(DEFAULT_MASTER),
    .MID_W         (MID_W)
  ) u_picker (
    .req       (bus.HBUSREQ),
`ifndef AHB_ARB_FIXED_PRIO_EN
    .last_owner(rr_ptr_reg),
`endif
    .grant     (pick_grant)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      grant_reg     <= DEFAULT_GRANT;
      hmaster_reg   <= DEFAULT_MID;
      hmaster_d_reg <= DEFAULT_MID;
      hmastlock_reg <= 1'b0;
      beat_cnt_reg  <= '0;
      state_reg     <= ARB_OWN;
`ifndef AHB_ARB_FIXED_PRIO_EN
      rr_ptr_reg    <= DEFAULT_MID;
`endif
    end else if (bus.HREADY) begin
      hmaster_reg   <= owner;
      hmaster_d_reg <= hmaster_reg;
      hmastlock_reg <= bus.HLOCK[owner];

      if (trans == NONSEQ)
        beat_cnt_reg <= BEAT_CNT_W'(burst_beats(burst) - 5'd1);
      else if ((trans == SEQ) && (beat_cnt_reg != '0))
        beat_cnt_reg <= beat_cnt_reg - BEAT_CNT_W'(1);

      case (state_reg)
        ARB_OWN, ARB_BURST: begin
          if (lock_req)
            state_reg <= ARB_LOCK;
          else if (trans == NONSEQ)
            state_reg <= fixed_burst ? ARB_BURST : ARB_OWN;
          else if (final_seq)
            state_reg <= ARB_OWN;
        end
        ARB_LOCK: begin
          // Lock may only be released between transfers, never inside a burst.
          if (!bus.HLOCK[owner] && (trans != SEQ) && (trans != BUSY))
            state_reg <= ((trans == NONSEQ) && fixed_burst) ? ARB_BURST : ARB_OWN;
        end
        default: state_reg <= ARB_OWN;
      endcase

      if (legal_point) begin
        grant_reg  <= pick_grant;
`ifndef AHB_ARB_FIXED_PRIO_EN
        rr_ptr_reg <= onehot_idx(pick_grant);
`endif
      end
    end
  end

  assign bus.HGRANT    = grant_reg;
  assign bus.HMASTER   = hmaster_reg;
  assign bus.HMASTER_D = hmaster_d_reg;
  assign bus.HMASTLOCK = hmastlock_reg;
endmodule

// File: doc/ahb_bus_arbiter.md
Name: ahb_bus_arbiter

Overview:
- Multi-master AHB (AMBA2) arbiter for the slave-verification environment's bus fabric.
- Shares one AHB slave port between NUM_MASTERS requesters, round-robin by default.
- Honours HLOCK and holds ownership until a fixed-length burst completes.
- Drives HGRANT, HMASTER and HMASTLOCK, which select the address/data muxes in front of the DUT slave.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..8).
- DEFAULT_MASTER, 0, index granted when no master requests.
- MID_W, $clog2(NUM_MASTERS), width of master index.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HBUSREQ  in  NUM_MASTERS  per-master bus request.
- HLOCK  in  NUM_MASTERS  per-master locked-transfer request.
- HTRANS  in  2  muxed transfer type of current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  in  3  muxed burst type of current owner.
- HREADY  in  1  slave ready; qualifies every ownership/counter update.
- HGRANT  out  NUM_MASTERS  one-hot grant, registered.
- HMASTER  out  MID_W  address-phase owner index, registered.
- HMASTER_D  out  MID_W  data-phase owner index, registered.
- HMASTLOCK  out  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESET=1 at edge): HGRANT=one-hot(DEFAULT_MASTER); HMASTER=HMASTER_D=DEFAULT_MASTER; HMASTLOCK=0; beat counter=0; state=ARB_OWN; rr pointer=DEFAULT_MASTER. Reset mid-burst aborts the burst immediately.
- FSM:
  - ARB_OWN: owner may be re-arbitrated at a legal point.
  - ARB_BURST: fixed-length burst in progress; grant frozen.
  - ARB_LOCK: owner holds HLOCK; grant frozen.
- Beat counter: loaded on NONSEQ with HREADY=1 to 4/8/16 minus 1 for INCR4|WRAP4 / INCR8|WRAP8 / INCR16|WRAP16. Decrements on SEQ with HREADY=1; BUSY holds it.
  - ARB_OWN→ARB_BURST on NONSEQ of a fixed burst.
  - ARB_BURST→ARB_OWN when the counter reaches 0 on an accepted SEQ.
- Lock: ARB_OWN/ARB_BURST→ARB_LOCK when HLOCK[owner]=1 and HBUSREQ[owner]=1 with HREADY=1. Exit when HLOCK[owner]=0 at an HREADY=1 edge with HTRANS≠SEQ/BUSY.
- Legal arbitration point (HREADY=1, state ARB_OWN), any of:
  - HTRANS=IDLE;
  - HTRANS=NONSEQ with SINGLE;
  - INCR undefined-length with HBUSREQ[owner]=0;
  - final SEQ of a fixed burst.
- At a legal point, HGRANT is updated for the next cycle: round-robin search from owner+1 mod NUM_MASTERS over HBUSREQ. If none request, grant DEFAULT_MASTER. If only the owner requests, keep the owner.
- Ownership transfer: on every edge with HREADY=1, HMASTER<=index(HGRANT), HMASTLOCK<=HLOCK[index(HGRANT)], HMASTER_D<=HMASTER. Latency is request→HGRANT 1 cycle after the legal point, and HGRANT→HMASTER at the next HREADY=1 edge.
- HREADY=0: HGRANT, HMASTER, HMASTER_D, HMASTLOCK, counter and state all hold.
- Owner dropping HBUSREQ mid fixed burst does not end the burst; the grant is held until the final beat.
- Simultaneous requests from all masters: pure rotation, no starvation; each master is granted at most NUM_MASTERS-1 arbitration points after requesting.
- HGRANT is always exactly one-hot.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: round-robin is replaced by fixed priority, lowest index highest, and the rr pointer is removed. Lock/burst rules are unchanged.
- Undefined: round-robin as above.

Decomposition:
- Shared package ahb_arb_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ);
  - hburst_e (SINGLE, INCR, WRAP4, INCR4, WRAP8, INCR8, WRAP16, INCR16);
  - arb_state_e (ARB_OWN, ARB_BURST, ARB_LOCK);
  - function burst_beats(hburst_e) returning beat count.
- One sub-module, ahb_rr_picker: combinational round-robin/priority selector taking request vector and last owner, returning a one-hot grant.

Test Plan:
- Reset, no requests: HGRANT=4'b0001, HMASTER=0, HMASTLOCK=0 for 10 cycles.
- Masters 1 and 3 request, SINGLE NONSEQ transfers, HREADY=1: grants alternate 1,3,1,3; HMASTER follows one cycle after HGRANT; HMASTER_D lags HMASTER by one cycle.
- Master 2 does INCR8 while master 0 requests from beat 3; HREADY low for 2 cycles at beat 5: HGRANT stays 4'b0100 through all 8 beats plus stalls; master 0 is granted the cycle after the last SEQ is accepted.
- Master 1 with HLOCK=1 does two SINGLE transfers; master 2 requests throughout: HMASTLOCK=1 while master 1 owns; no grant to 2 until HLOCK[1]=0 with HTRANS=IDLE.
- HRESET asserted at beat 4 of WRAP16: next cycle HGRANT=4'b0001, HMASTER=0, state ARB_OWN, counter 0.
- AHB_ARB_FIXED_PRIO_EN defined, masters 0 and 3 request continuously with SINGLE transfers: master 0 granted every arbitration point, master 3 never.
